// File: rtl/click_sync_rx.sv
// Receiving bridge from a 2-phase bundled-data click pipeline into the clk domain.
// Synchronises the request phase, acknowledges on capture, and buffers tokens in a small FIFO.
module click_sync_rx #(
    parameter int   DATA_WIDTH  = 2,
    parameter int   DEPTH       = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic PHASE_INIT  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_req,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic req_s, pending, full, push, pop, valid;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_req};
        req_s    = sync_q[SYNC_STAGES-1];
        pending  = req_s ^ ack_q;
        full     = (level_q == LW'(DEPTH));
        // Registered full only: a same-cycle pop never lets the waiting token in.
        push     = pending & ~full;
        valid    = (level_q != '0);
        pop      = valid & out_ready;
        ack_d    = ack_q ^ push;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{PHASE_INIT}};
            ack_q    <= PHASE_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy tracking alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ack    = ack_q;
    assign out_valid = valid;
    assign out_data  = valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;

endmodule
